// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - bus widths, op bit indices and branch condition helper for mem_stage
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_WD = 121;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_TO_ES_BUS_WD = 32;
  localparam int MS_TO_FW_BUS_WD = 6;
  localparam int BR_BUS_WD       = 33;

  localparam int LOAD_OP_WD   = 5;
  localparam int BRANCH_OP_WD = 9;

  localparam int LD_B  = 0;
  localparam int LD_H  = 1;
  localparam int LD_W  = 2;
  localparam int LD_BU = 3;
  localparam int LD_HU = 4;

  localparam int BR_BEQ  = 0;
  localparam int BR_BNE  = 1;
  localparam int BR_BLT  = 2;
  localparam int BR_BGE  = 3;
  localparam int BR_BLTU = 4;
  localparam int BR_BGEU = 5;
  localparam int BR_B    = 6;
  localparam int BR_BL   = 7;
  localparam int BR_JIRL = 8;

  // Flags come from src1 - src2 in EX; flag_c is the unsigned borrow.
  function automatic logic branch_cond(input logic [BRANCH_OP_WD-1:0] op,
                                       input logic flag_c, input logic flag_s,
                                       input logic flag_v, input logic flag_z);
    return (op[BR_BEQ]  &&  flag_z)
        || (op[BR_BNE]  && !flag_z)
        || (op[BR_BLT]  &&  (flag_s ^ flag_v))
        || (op[BR_BGE]  && !(flag_s ^ flag_v))
        || (op[BR_BLTU] &&  flag_c)
        || (op[BR_BGEU] && !flag_c)
        || op[BR_B] || op[BR_BL] || op[BR_JIRL];
  endfunction
endpackage

// File: rtl/mem_stage_load_ext.sv
// rtl/mem_stage_load_ext.sv - load lane select and sign/zero extension
module mem_stage_load_ext import mem_stage_pkg::*; (
  input  logic [LOAD_OP_WD-1:0] load_op,
  input  logic [1:0]            addr,
  input  logic [31:0]           rdata,
  output logic [31:0]           result
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    result = '0;
    if (load_op[LD_B])  result = {{24{byte_sel[7]}}, byte_sel};
    if (load_op[LD_H])  result = {{16{half_sel[15]}}, half_sel};
    if (load_op[LD_W])  result = rdata;
    if (load_op[LD_BU]) result = {24'd0, byte_sel};
    if (load_op[LD_HU]) result = {16'd0, half_sel};
  end
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with load merge and branch resolution
module mem_stage import mem_stage_pkg::*; (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
  output logic [MS_TO_FW_BUS_WD-1:0] ms_to_fw_bus,
  output logic [BR_BUS_WD-1:0]       br_bus
);
  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
  logic                       first_r;
  logic [31:0]                rdata_r;
  logic                       br_done_r;

  logic [31:0]              br_target;
  logic [BRANCH_OP_WD-1:0]  branch_op;
  logic                     flag_c, flag_s, flag_v, flag_z;
  logic [LOAD_OP_WD-1:0]    load_op;
  logic                     mem_to_reg;
  logic                     reg_we;
  logic [4:0]               dest;
  logic [31:0]              ms_result;
  logic [31:0]              ms_pc;

  assign {br_target, branch_op, flag_c, flag_s, flag_v, flag_z,
          load_op, mem_to_reg, reg_we, dest, ms_result, ms_pc} = es_to_ms_bus_r;

  logic        ms_entry;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        br_taken;

  assign ms_allowin     = !ms_valid || ws_allowin;
  assign ms_to_ws_valid = ms_valid;
  assign ms_entry       = es_to_ms_valid && ms_allowin;

  // SRAM data is only valid right after entry; later stall cycles use the captured copy.
  assign mem_rdata = first_r ? data_sram_rdata : rdata_r;

  mem_stage_load_ext u_load_ext (
    .load_op (load_op),
    .addr    (ms_result[1:0]),
    .rdata   (mem_rdata),
    .result  (load_data)
  );

  assign final_result = mem_to_reg ? load_data : ms_result;
  assign br_taken     = ms_valid && branch_cond(branch_op, flag_c, flag_s, flag_v, flag_z)
                        && !br_done_r;

  assign ms_to_ws_bus = {reg_we, dest, final_result, ms_pc};
  assign ms_to_es_bus = ms_result;
  assign ms_to_fw_bus = {dest, reg_we && ms_valid};
  assign br_bus       = {br_taken, br_target};

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid       <= 1'b0;
      es_to_ms_bus_r <= '0;
      first_r        <= 1'b0;
      rdata_r        <= '0;
      br_done_r      <= 1'b0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (ms_entry)   es_to_ms_bus_r <= es_to_ms_bus;
      first_r <= ms_entry;
      if (first_r && ms_valid) rdata_r <= data_sram_rdata;
      if (ms_entry)      br_done_r <= 1'b0;
      else if (br_taken) br_done_r <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with directed and randomized scenarios
module tb_mem_stage;
  logic         clk;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [120:0] es_to_ms_bus;
  logic [31:0]  data_sram_rdata;
  logic         ms_to_ws_valid;
  logic [69:0]  ms_to_ws_bus;
  logic [31:0]  ms_to_es_bus;
  logic [5:0]   ms_to_fw_bus;
  logic [32:0]  br_bus;

  int vectors = 0;
  int errors  = 0;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_to_es_bus    (ms_to_es_bus),
    .ms_to_fw_bus    (ms_to_fw_bus),
    .br_bus          (br_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags are packed {C, S, V, Z}
  function automatic logic [120:0] mk(input logic [31:0] tgt, input logic [8:0] bop,
                                      input logic [3:0] flags, input logic [4:0] lop,
                                      input logic m2r, input logic we, input logic [4:0] dest,
                                      input logic [31:0] res, input logic [31:0] pc);
    return {tgt, bop, flags, lop, m2r, we, dest, res, pc};
  endfunction

  function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (int'(a) * 8)) & 32'hFF;
    h = (d >> (a[1] ? 16 : 0)) & 32'hFFFF;
    case (op)
      5'b00001: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      5'b00010: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      5'b00100: return d;
      5'b01000: return b;
      5'b10000: return h;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [8:0] bop, input logic [3:0] f);
    logic c, s, v, z;
    logic lt;
    {c, s, v, z} = f;
    lt = (s != v);
    case (bop)
      9'h001:  return z;
      9'h002:  return !z;
      9'h004:  return lt;
      9'h008:  return !lt;
      9'h010:  return c;
      9'h020:  return !c;
      9'h040, 9'h080, 9'h100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [120:0] bus);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_rdata = '0;
    repeat (3) tick();
    #1;
    vectors++;
    if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ms_to_ws_valid); end
    vectors++;
    if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b expected 1", ms_allowin); end
    vectors++;
    if (br_bus !== 33'd0) begin errors++; $display("FAIL reset_br_bus: got %h expected 0", br_bus); end
    vectors++;
    if (ms_to_fw_bus[0] !== 1'b0) begin errors++; $display("FAIL reset_fw_we: got %b expected 0", ms_to_fw_bus[0]); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_byte();
    ws_allowin = 1'b1;
    enter(mk(32'h0, 9'h0, 4'h0, 5'b00001, 1'b1, 1'b1, 5'd3, 32'h1000_0003, 32'h1C00_0000));
    data_sram_rdata = 32'h80FF_1234;
    #1;
    vectors++;
    if (ms_to_ws_bus[63:32] !== 32'hFFFF_FF80) begin errors++; $display("FAIL ld_b: got %h expected ffffff80", ms_to_ws_bus[63:32]); end
    tick();
    enter(mk(32'h0, 9'h0, 4'h0, 5'b01000, 1'b1, 1'b1, 5'd3, 32'h1000_0003, 32'h1C00_0004));
    data_sram_rdata = 32'h80FF_1234;
    #1;
    vectors++;
    if (ms_to_ws_bus[63:32] !== 32'h0000_0080) begin errors++; $display("FAIL ld_bu: got %h expected 00000080", ms_to_ws_bus[63:32]); end
    tick();
  endtask

  task automatic test_stall_hold();
    ws_allowin = 1'b0;
    enter(mk(32'h0, 9'h0, 4'h0, 5'b00010, 1'b1, 1'b1, 5'd7, 32'h2000_0002, 32'h1C00_0008));
    data_sram_rdata = 32'h8001_7FFF;
    #1;
    vectors++;
    if (ms_to_ws_bus[63:32] !== 32'hFFFF_8001) begin errors++; $display("FAIL ld_h_first: got %h expected ffff8001", ms_to_ws_bus[63:32]); end
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      vectors++;
      if (ms_to_ws_bus[63:32] !== 32'hFFFF_8001) begin errors++; $display("FAIL ld_h_stall%0d: got %h expected ffff8001", i, ms_to_ws_bus[63:32]); end
      vectors++;
      if ({ms_to_ws_valid, ms_allowin} !== 2'b10) begin errors++; $display("FAIL stall_hs%0d: got %b expected 10", i, {ms_to_ws_valid, ms_allowin}); end
    end
    ws_allowin = 1'b1;
    tick();
    vectors++;
    if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", ms_to_ws_valid); end
  endtask

  task automatic test_branch_pulse();
    int pulses;
    ws_allowin = 1'b0;
    enter(mk(32'h1C00_0040, 9'h004, 4'b0100, 5'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_0010));
    vectors++;
    if (br_bus !== {1'b1, 32'h1C00_0040}) begin errors++; $display("FAIL blt_pulse: got %h expected 11c000040", br_bus); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (br_bus[32]) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin errors++; $display("FAIL blt_repeat: got %0d extra pulses expected 0", pulses); end
    ws_allowin = 1'b1;
    tick();
    enter(mk(32'h1C00_0040, 9'h008, 4'b0100, 5'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_0014));
    pulses = br_bus[32] ? 1 : 0;
    tick();
    vectors++;
    if (pulses !== 0) begin errors++; $display("FAIL bge_pulse: got %0d pulses expected 0", pulses); end
  endtask

  task automatic test_back_to_back();
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(32'h1C00_0100, 9'h002, 4'b0000, 5'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1C00_0020);
    tick();
    es_to_ms_bus = mk(32'h1C00_0200, 9'h100, 4'b0001, 5'b0, 1'b0, 1'b1, 5'd1, 32'h1C00_0028, 32'h1C00_0024);
    vectors++;
    if (br_bus !== {1'b1, 32'h1C00_0100}) begin errors++; $display("FAIL b2b_bne: got %h expected 11c000100", br_bus); end
    tick();
    es_to_ms_valid = 1'b0;
    vectors++;
    if (br_bus !== {1'b1, 32'h1C00_0200}) begin errors++; $display("FAIL b2b_jirl: got %h expected 11c000200", br_bus); end
    tick();
    vectors++;
    if (br_bus[32] !== 1'b0) begin errors++; $display("FAIL b2b_after: got %b expected 0", br_bus[32]); end
  endtask

  task automatic test_reset_mid_stall();
    ws_allowin = 1'b0;
    enter(mk(32'h1C00_0300, 9'h100, 4'b0, 5'b00100, 1'b1, 1'b1, 5'd9, 32'h3000_0000, 32'h1C00_0030));
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({ms_to_ws_valid, ms_allowin, ms_to_fw_bus[0]} !== 3'b010) begin errors++; $display("FAIL rst_stall_hs: got %b expected 010", {ms_to_ws_valid, ms_allowin, ms_to_fw_bus[0]}); end
    vectors++;
    if (br_bus !== 33'd0) begin errors++; $display("FAIL rst_stall_br: got %h expected 0", br_bus); end
    tick();
    vectors++;
    if (br_bus[32] !== 1'b0) begin errors++; $display("FAIL rst_stall_nopulse: got %b expected 0", br_bus[32]); end
    ws_allowin = 1'b1;
  endtask

  task automatic test_alu();
    ws_allowin = 1'b1;
    enter(mk(32'h0, 9'h0, 4'h0, 5'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0040));
    vectors++;
    if (ms_to_ws_bus !== {1'b1, 5'd5, 32'h1234_5678, 32'h1C00_0040}) begin errors++; $display("FAIL alu_ws_bus: got %h", ms_to_ws_bus); end
    vectors++;
    if (ms_to_es_bus !== 32'h1234_5678) begin errors++; $display("FAIL alu_es_bus: got %h expected 12345678", ms_to_es_bus); end
    vectors++;
    if (ms_to_fw_bus !== {5'd5, 1'b1}) begin errors++; $display("FAIL alu_fw_bus: got %h expected 0b", ms_to_fw_bus); end
    tick();
  endtask

  task automatic test_random();
    logic         m_valid, m_first, m_pulsed;
    logic [120:0] m_bus;
    logic [31:0]  m_data, exp_final;
    logic         exp_taken;
    logic [4:0]   lop;
    logic [8:0]   bop;
    m_valid = 1'b0; m_first = 1'b0; m_pulsed = 1'b0; m_bus = '0; m_data = '0;
    for (int i = 0; i < 400; i++) begin
      lop = 5'b00001 << $urandom_range(0, 4);
      bop = ($urandom_range(0, 1) == 1) ? (9'b1 << $urandom_range(0, 8)) : 9'b0;
      es_to_ms_valid  = ($urandom_range(0, 2) != 0);
      es_to_ms_bus    = mk($urandom, bop, 4'($urandom), lop, 1'($urandom), 1'($urandom),
                           5'($urandom), $urandom, $urandom);
      ws_allowin      = ($urandom_range(0, 2) != 0);
      data_sram_rdata = $urandom;
      #1;
      if (m_valid && m_first) m_data = data_sram_rdata;
      m_first = 1'b0;
      vectors++;
      if (ms_allowin !== (!m_valid || ws_allowin)) begin errors++; $display("FAIL rnd_allowin@%0d: got %b", i, ms_allowin); end
      vectors++;
      if (ms_to_ws_valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, ms_to_ws_valid, m_valid); end
      exp_taken = m_valid && ref_taken(m_bus[88:80], m_bus[79:76]) && !m_pulsed;
      vectors++;
      if (br_bus[32] !== exp_taken) begin errors++; $display("FAIL rnd_br_taken@%0d: got %b expected %b", i, br_bus[32], exp_taken); end
      if (exp_taken) m_pulsed = 1'b1;
      if (m_valid) begin
        exp_final = m_bus[70] ? ref_load(m_bus[75:71], m_bus[33:32], m_data) : m_bus[63:32];
        vectors++;
        if (ms_to_ws_bus !== {m_bus[69:64], exp_final, m_bus[31:0]}) begin errors++; $display("FAIL rnd_ws_bus@%0d: got %h expected %h", i, ms_to_ws_bus, {m_bus[69:64], exp_final, m_bus[31:0]}); end
        vectors++;
        if ({ms_to_fw_bus, ms_to_es_bus, br_bus[31:0]} !== {m_bus[68:64], m_bus[69], m_bus[63:32], m_bus[120:89]}) begin errors++; $display("FAIL rnd_side_bus@%0d: got %h %h %h", i, ms_to_fw_bus, ms_to_es_bus, br_bus[31:0]); end
      end else begin
        vectors++;
        if (ms_to_fw_bus[0] !== 1'b0) begin errors++; $display("FAIL rnd_fw_idle@%0d: got %b expected 0", i, ms_to_fw_bus[0]); end
      end
      @(posedge clk);
      if (!m_valid || ws_allowin) begin
        m_valid = es_to_ms_valid;
        if (es_to_ms_valid) begin
          m_bus = es_to_ms_bus;
          m_first = 1'b1;
          m_pulsed = 1'b0;
        end
      end
      #1;
    end
    es_to_ms_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_stall_hold();
    test_branch_pulse();
    test_back_to_back();
    test_reset_mid_stall();
    test_alu();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage LoongArch-subset pipeline, between `exe_stage` and `wb_stage`. Latches the execute bundle and merges synchronous data-SRAM read data with load-op sign/zero extension. Resolves conditional branches from the ALU flags computed in EX and redirects fetch with a single-pulse branch bus. Provides forwarding and hazard information back to EX.

## Interface
Parameters: none; widths come from the shared header.

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `ws_allowin`  in  1  WB can accept
- `ms_allowin`  out  1  MS can accept
- `es_to_ms_valid`  in  1  EX bundle valid
- `es_to_ms_bus`  in  121  fields:
  - `br_target` [120:89]
  - `branch_op` [88:80]
  - flags: C [79], S [78], V [77], Z [76]
  - `load_op` [75:71]
  - `mem_to_reg` [70]
  - `reg_we` [69]
  - `dest` [68:64]
  - `result` [63:32]
  - `pc` [31:0]
- `data_sram_rdata`  in  32  read data for the address EX issued last cycle
- `ms_to_ws_valid`  out  1  bundle valid to WB
- `ms_to_ws_bus`  out  70  fields: `reg_we` [69], `dest` [68:64], `final_result` [63:32], `pc` [31:0]
- `ms_to_es_bus`  out  32  `ms_result` (ALU result) for EX forwarding
- `ms_to_fw_bus`  out  6  fields: `dest` [5:1], `reg_we & ms_valid` [0]
- `br_bus`  out  33  fields: `br_taken` [32], `br_target` [31:0]

## Operation
- **Handshake**
  - `ms_ready_go` = 1.
  - `ms_allowin = !ms_valid || ws_allowin`.
  - `ms_to_ws_valid = ms_valid`.
  - The bus register loads on `es_to_ms_valid && ms_allowin`.
  - `ms_valid` loads `es_to_ms_valid` whenever `ms_allowin`.
- **Read-data capture**
  - SRAM rdata is valid only in the first cycle after entry.
  - `first_r` is set on entry and cleared the next cycle.
  - While `first_r && ms_valid`, `rdata_r <= data_sram_rdata`.
  - Effective data = `first_r ? data_sram_rdata : rdata_r`. Data therefore survives any number of WB stall cycles.
- **Load extension** (`load_op` one-hot; byte/half lane selected by `result[1:0]`)
  - [0] ld.b: sign-extend byte
  - [1] ld.h: sign-extend half (`result[1]` selects half)
  - [2] ld.w: full word
  - [3] ld.bu: zero-extend byte
  - [4] ld.hu: zero-extend half
  - `final_result = mem_to_reg ? load_data : result`.
- **Branch condition** (flags from src1−src2; C=1 means unsigned borrow)
  - `branch_op` [0] beq: Z
  - [1] bne: !Z
  - [2] blt: S^V
  - [3] bge: !(S^V)
  - [4] bltu: C
  - [5] bgeu: !C
  - [6] b, [7] bl, [8] jirl: always taken
- **Branch pulse**
  - `br_taken = ms_valid && cond && !br_done_r`.
  - `br_done_r` sets when `br_taken` fires and clears when a new bundle enters. Exactly one pulse per branch, even while stalled.
  - `br_target` is passed through unchanged.
  - Upstream flush is owned by IF/ID/EX; MS does not flush itself.

## Timing
- Reset values:
  - `ms_valid`, `first_r`, `br_done_r` = 0.
  - `rdata_r` = 0.
  - `ms_to_ws_valid` = 0, `br_bus` = 0.
  - `ms_to_fw_bus[0]` = 0.
  - `ms_allowin` = 1.
- Latency: one cycle EX→MS. `final_result` is combinational from the bus register plus rdata in the same cycle.
- Entry while stalled: blocked (`ms_allowin` = 0), so the bus register and `rdata_r` are stable.
- Simultaneous drain and entry (`ws_allowin` = 1, `ms_valid` = 1, new EX valid): the new bundle loads, `first_r` = 1, `br_done_r` = 0.
- Reset asserted mid-stall: all state clears next edge. No `br_taken` pulse follows reset.
- Invalid bundle: `br_taken` = 0 and fw `reg_we` = 0 regardless of bus contents.
- Misaligned half/word: no exception. The lane is taken from `result[1:0]` as defined above.

## Structure
- Shared header `mycpu.v` holds the following, with field-offset comments:
  - `ES_TO_MS_BUS_WD` = 121
  - `MS_TO_WS_BUS_WD` = 70
  - `MS_TO_ES_BUS_WD` = 32
  - `MS_TO_FW_BUS_WD` = 6
  - `BR_BUS_WD` = 33
  - load_op and branch_op bit indices as constants
- One sub-module is natural: `load_ext` (combinational; `load_op`, addr[1:0], rdata → 32-bit result). Everything else stays in `mem_stage`.

## Test plan
- ld.b at addr low bits 2'b11, rdata `0x80FF1234`: `final_result` = `0xFFFFFF80`. Same with ld.bu: `0x00000080`.
- ld.h at low bits 2'b10, rdata `0x8001_7FFF`, `ws_allowin` low for 3 cycles while rdata changes to `0xDEADBEEF`: output stays `0xFFFF8001` until accepted.
- blt with S=1, V=0, `br_target` `0x1C000040`, WB stalled 4 cycles: `br_bus` = {1, `0x1C000040`} for exactly one cycle. bge with the same flags gives no pulse.
- Back-to-back bne (Z=0) then jirl with `ws_allowin` = 1: two consecutive single-cycle pulses with the correct targets.
- Reset asserted during a stalled ld.w: next cycle `ms_valid` = 0, `ms_to_ws_valid` = 0, `ms_allowin` = 1, `br_bus` = 0.
- ALU op (`mem_to_reg` = 0, `reg_we` = 1, dest 5, result `0x12345678`): `ms_to_ws_bus` carries dest 5 and `0x12345678`; `ms_to_es_bus` = `0x12345678`; `ms_to_fw_bus` = {5, 1}.
